// File: rtl/i2c_slave_responder_if.sv
// i2c_slave_responder_if: open-drain I2C bus pins seen by the target endpoint
interface i2c_slave_responder_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;
  modport slave (input scl_in, sda_in, output sda_oe);
  modport master (output scl_in, sda_in, input sda_oe);
endinterface

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target that matches an address, ACKs it, then receives write bytes or shifts out read bytes
module i2c_slave_responder #(
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic                clk,
  input  logic                rst,
  i2c_slave_responder_if.slave bus,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_load,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                addr_match,
  output logic                rw,
  output logic                master_nack,
  output logic                busy
);
  typedef enum logic [2:0] {
    IDLE, GET_ADDR, ADDR_ACK, WRITE_RECV, WRITE_ACK, READ_SEND, READ_ACK_CHECK, IGNORE
  } state_t;
  localparam logic [3:0] A_LAST = 4'(ADDR_LEN);
  localparam logic [3:0] D_LAST = 4'(DATA_LEN - 1);
  localparam logic [3:0] D_LEN = 4'(DATA_LEN);
  state_t state;
  logic [1:0] scl_s, sda_s;
  logic scl_d, sda_d;
  logic [3:0] bit_cnt;
  logic [ADDR_LEN-1:0] addr_sh;
  logic [DATA_LEN-1:0] rx_sh, tx_sh;
  logic phase;
  logic scl, sda, scl_rise, scl_fall, start, stop;
  always_comb begin
    scl = scl_s[1];
    sda = sda_s[1];
    scl_rise = scl & ~scl_d;
    scl_fall = ~scl & scl_d;
    start = scl & scl_d & sda_d & ~sda;
    stop = scl & scl_d & ~sda_d & sda;
  end
  // phase marks the second half of an ACK slot (ours in *_ACK, the master's in READ_ACK_CHECK)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      bit_cnt <= '0;
      addr_sh <= '0;
      rx_sh <= '0;
      tx_sh <= '0;
      phase <= 1'b0;
      bus.sda_oe <= 1'b0;
      tx_load <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      addr_match <= 1'b0;
      rw <= 1'b0;
      master_nack <= 1'b0;
      busy <= 1'b0;
    end else begin
      scl_s <= {scl_s[0], bus.scl_in};
      sda_s <= {sda_s[0], bus.sda_in};
      scl_d <= scl;
      sda_d <= sda;
      tx_load <= 1'b0;
      rx_valid <= 1'b0;
      addr_match <= 1'b0;
      master_nack <= 1'b0;
      if (start) begin
        state <= GET_ADDR;
        bit_cnt <= '0;
        bus.sda_oe <= 1'b0;
        busy <= 1'b0;
      end else if (stop) begin
        state <= IDLE;
        bit_cnt <= '0;
        bus.sda_oe <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          GET_ADDR: if (scl_rise) begin
            addr_sh <= {addr_sh[ADDR_LEN-2:0], sda};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == A_LAST) begin
              bit_cnt <= '0;
              phase <= 1'b0;
              if (addr_sh == SLAVE_ADDR) begin
                addr_match <= 1'b1;
                rw <= sda;
                busy <= 1'b1;
                state <= ADDR_ACK;
              end else state <= IGNORE;
            end
          end
          ADDR_ACK, WRITE_ACK: if (scl_fall) begin
            phase <= ~phase;
            if (!phase) bus.sda_oe <= 1'b1;
            else if (state == ADDR_ACK && rw) begin
              tx_sh <= tx_data << 1;
              bus.sda_oe <= ~tx_data[DATA_LEN-1];
              tx_load <= 1'b1;
              bit_cnt <= 4'd1;
              state <= READ_SEND;
            end else begin
              bus.sda_oe <= 1'b0;
              state <= WRITE_RECV;
            end
          end
          WRITE_RECV: if (scl_rise) begin
            rx_sh <= {rx_sh[DATA_LEN-2:0], sda};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == D_LAST) begin
              bit_cnt <= '0;
              phase <= 1'b0;
              rx_data <= {rx_sh[DATA_LEN-2:0], sda};
              rx_valid <= 1'b1;
              state <= WRITE_ACK;
            end
          end
          READ_SEND: if (scl_fall) begin
            if (bit_cnt == D_LEN) begin
              bus.sda_oe <= 1'b0;
              bit_cnt <= '0;
              phase <= 1'b0;
              state <= READ_ACK_CHECK;
            end else begin
              bus.sda_oe <= ~tx_sh[DATA_LEN-1];
              tx_sh <= tx_sh << 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          READ_ACK_CHECK: if (scl_rise) begin
            if (sda) begin
              master_nack <= 1'b1;
              busy <= 1'b0;
              state <= IGNORE;
            end else phase <= 1'b1;
          end else if (scl_fall && phase) begin
            phase <= 1'b0;
            tx_sh <= tx_data << 1;
            bus.sda_oe <= ~tx_data[DATA_LEN-1];
            tx_load <= 1'b1;
            bit_cnt <= 4'd1;
            state <= READ_SEND;
          end
          default: bus.sda_oe <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: randomized bus-master bench with a pulse-event scoreboard
module tb_i2c_slave_responder;
  localparam int Q = 4;
  localparam int H = 8;
  localparam logic [6:0] ADDR = 7'h50;
  typedef struct {int kind; logic [7:0] val;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_load, rx_valid, addr_match, rw, master_nack, busy;
  logic [7:0] rx_data;
  int vectors = 0;
  int errs = 0;
  ev_t exp_q[$];
  logic oe_seen = 1'b0;
  logic prev_oe = 1'b0;
  i2c_slave_responder_if bus();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;
  i2c_slave_responder dut (
    .clk(clk), .rst(rst), .bus(bus), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .addr_match(addr_match), .rw(rw),
    .master_nack(master_nack), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic expect_ev(input int k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val = v;
    exp_q.push_back(e);
  endtask
  // kinds: 0 addr_match {busy,rw}, 1 rx_valid rx_data, 2 tx_load sda_oe, 3 master_nack busy
  always @(negedge clk) begin
    logic [3:0] p;
    ev_t g, e;
    p = {master_nack, tx_load, rx_valid, addr_match};
    if (!rst) begin
      if (bus.sda_oe) oe_seen <= 1'b1;
      if (bus.sda_oe != prev_oe && scl_m) begin
        errs++;
        $display("FAIL hold: sda_oe changed to %b while SCL high, required stable", bus.sda_oe);
      end
      if (p != 4'b0) begin
        vectors++;
        g.kind = addr_match ? 0 : rx_valid ? 1 : tx_load ? 2 : 3;
        g.val = addr_match ? {6'b0, busy, rw} : rx_valid ? rx_data : tx_load ? {7'b0, bus.sda_oe} : {7'b0, busy};
        if ($countones(p) != 1 || exp_q.size() == 0) begin
          errs++;
          $display("FAIL event: unexpected pulses %b (queued %0d), required none", p, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (e.kind != g.kind || e.val !== g.val) begin
            errs++;
            $display("FAIL event: got kind %0d val %h, required kind %0d val %h", g.kind, g.val, e.kind, e.val);
          end
        end
      end
    end
    prev_oe <= bus.sda_oe;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bit_out(input logic b);
    tick(Q);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(H);
    scl_m = 1'b0;
  endtask
  task automatic bit_in(output logic b);
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    b = bus.sda_in;
    tick(Q);
    scl_m = 1'b0;
  endtask
  task automatic start_c();
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(H);
    sda_m = 1'b0;
    tick(H);
    scl_m = 1'b0;
  endtask
  task automatic stop_c();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(H);
    sda_m = 1'b1;
    tick(H);
  endtask
  task automatic send_addr(input logic [6:0] a, input logic r);
    logic [7:0] ab;
    ab = {a, r};
    if (a == ADDR) expect_ev(0, {6'b0, 1'b1, r});
    for (int i = 7; i >= 0; i--) bit_out(ab[i]);
  endtask
  // reference: a matching target ACKs address and writes, returns tx bytes, else the bus floats high
  task automatic do_frame(input logic [6:0] a, input logic r, input logic [7:0] b0, input logic [7:0] b1,
                          input int n, input bit do_stop);
    logic hit, k;
    logic [7:0] byt, got;
    hit = (a == ADDR);
    start_c();
    send_addr(a, r);
    if (hit && r) begin
      tx_data = b0;
      expect_ev(2, {7'b0, ~b0[7]});
    end
    bit_in(k);
    check("addr_ack", {7'b0, k}, {7'b0, ~hit});
    for (int j = 0; j < n; j++) begin
      byt = (j == 0) ? b0 : b1;
      if (!r) begin
        if (hit) expect_ev(1, byt);
        for (int i = 7; i >= 0; i--) bit_out(byt[i]);
        bit_in(k);
        check("data_ack", {7'b0, k}, {7'b0, ~hit});
      end else begin
        for (int i = 7; i >= 0; i--) begin
          bit_in(k);
          got[i] = k;
        end
        check("read_byte", got, hit ? byt : 8'hFF);
        if (hit && j != n - 1) begin
          tx_data = b1;
          expect_ev(2, {7'b0, ~b1[7]});
        end
        if (hit && j == n - 1) expect_ev(3, 8'h00);
        bit_out(j == n - 1);
      end
    end
    if (do_stop) begin
      stop_c();
      check("busy_after_stop", {7'b0, busy}, 8'h00);
      check("oe_after_stop", {7'b0, bus.sda_oe}, 8'h00);
    end
  endtask
  initial begin
    logic k;
    int w;
    tick(4);
    rst = 1'b0;
    tick(1);
    check("rst_oe", {7'b0, bus.sda_oe}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_rw", {7'b0, rw}, 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {4'b0, master_nack, tx_load, rx_valid, addr_match}, 8'h00);
    tick(10);
    do_frame(ADDR, 1'b0, 8'hA5, 8'h00, 1, 1'b1);
    check("rx_data_a5", rx_data, 8'hA5);
    do_frame(ADDR, 1'b1, 8'h3C, 8'hC3, 2, 1'b1);
    oe_seen = 1'b0;
    do_frame(7'h51, 1'b0, 8'hFF, 8'h00, 1, 1'b1);
    check("mismatch_quiet", {7'b0, oe_seen}, 8'h00);
    do_frame(ADDR, 1'b0, 8'h11, 8'h00, 1, 1'b0);
    check("rw_before_sr", {7'b0, rw}, 8'h00);
    do_frame(ADDR, 1'b1, 8'h96, 8'h00, 1, 1'b1);
    check("rw_after_sr", {7'b0, rw}, 8'h01);
    start_c();
    send_addr(ADDR, 1'b0);
    w = 0;
    while (!bus.sda_oe && w < 40) begin
      tick(1);
      w++;
    end
    check("oe_before_rst", {7'b0, bus.sda_oe}, 8'h01);
    rst = 1'b1;
    tick(1);
    check("oe_in_rst", {7'b0, bus.sda_oe}, 8'h00);
    check("busy_in_rst", {7'b0, busy}, 8'h00);
    rst = 1'b0;
    stop_c();
    do_frame(ADDR, 1'b0, 8'h5A, 8'h00, 1, 1'b1);
    check("rx_after_rst", rx_data, 8'h5A);
    start_c();
    send_addr(ADDR, 1'b0);
    bit_in(k);
    check("mid_ack", {7'b0, k}, 8'h00);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    stop_c();
    check("busy_mid_stop", {7'b0, busy}, 8'h00);
    do_frame(ADDR, 1'b0, 8'hC7, 8'h00, 1, 1'b1);
    check("rx_after_mid_stop", rx_data, 8'hC7);
    for (int f = 0; f < 12; f++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
      do_frame(a, 1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 2), 1'b1);
    end
    tick(20);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
